// File: rtl/sic1_io_memory_pkg.sv
// Shared constants and types for the SIC-1 memory slice: default I/O map and the
// output FIFO entry layout.
package sic1_pkg;

    localparam int IN_BASE_ADDR  = 253;
    localparam int OUT_BASE_ADDR = 254;
    localparam int HALT_ADDR     = 255;
    localparam int FIFO_W        = 10;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sic1_io_memory_if.sv
// Core/pin-side bus of the SIC-1 memory: write port, two read ports, input
// handshakes and the buffered output stream.
interface sic1_io_memory_if #(
    parameter int ADDR_W    = 8,
    parameter int NUM_IN    = 1,
    parameter int OUT_DEPTH = 4
);
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [7:0]                wr_byte;
    logic [ADDR_W-3:0]         ra_addr;
    logic [ADDR_W-3:0]         rb_addr;
    logic [1:0]                pc_low;
    logic [7:0]                out_a;
    logic [7:0]                out_b;
    logic [7:0]                out_c;
    logic [1:0]                rb_byte_idx;
    logic [7:0]                rb_byte;
    logic                      rd_consume;
    logic [8*NUM_IN-1:0]       in_data;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN-1:0]         in_ack;
    logic [7:0]                out_data;
    logic [1:0]                out_chan;
    logic                      out_valid;
    logic                      out_ready;
    logic                      stall;
    logic [$clog2(OUT_DEPTH):0] fifo_level;

    modport master (
        output wr_en, wr_addr, wr_byte, ra_addr, rb_addr, pc_low, rb_byte_idx,
               rd_consume, in_data, in_valid, out_ready,
        input  out_a, out_b, out_c, rb_byte, in_ack, out_data, out_chan,
               out_valid, stall, fifo_level
    );

    modport slave (
        input  wr_en, wr_addr, wr_byte, ra_addr, rb_addr, pc_low, rb_byte_idx,
               rd_consume, in_data, in_valid, out_ready,
        output out_a, out_b, out_c, rb_byte, in_ack, out_data, out_chan,
               out_valid, stall, fifo_level
    );
endinterface

// File: rtl/sic1_io_memory_out_fifo.sv
// Synchronous FIFO buffering output bytes (with their channel index) between the
// core and the output pins.
module sic1_out_fifo
    import sic1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fifo_entry_t            push_data,
    output logic                   full,
    input  logic                   pop,
    output fifo_entry_t            pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sic1_io_memory.sv
// SIC-1 byte-lane data/instruction memory with memory-mapped input channels and a
// buffered, stalling output path.
module sic1_io_memory
    import sic1_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_IN    = 1,
    parameter int NUM_OUT   = 1,
    parameter int IN_BASE   = IN_BASE_ADDR,
    parameter int OUT_BASE  = OUT_BASE_ADDR,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sic1_io_memory_if.slave  bus
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int WORDS = 1 << WA_W;

    logic [7:0]      lane_mem [4][WORDS];
    logic [WA_W-1:0] ra_q;
    logic [WA_W-1:0] rb_q;
    logic [31:0]     word_a;
    logic [31:0]     word_b;
    logic [63:0]     span;
    logic            wr_io;
    logic            out_hit;
    logic [1:0]      wr_chan;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    fifo_entry_t     push_entry;
    fifo_entry_t     head;

    function automatic logic [7:0] map_byte(input logic [ADDR_W-1:0] a,
                                            input logic [7:0] stored,
                                            input logic [8*NUM_IN-1:0] din,
                                            input logic [NUM_IN-1:0] vin);
        logic [7:0] r;
        r = stored;
        for (int k = 0; k < NUM_IN; k++) begin
            if (a == ADDR_W'(IN_BASE + k)) begin
                r = vin[k] ? din[8*k +: 8] : 8'h00;
            end
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (a == ADDR_W'(OUT_BASE + k)) begin
                r = 8'h00;
            end
        end
        return r;
    endfunction

    always_comb begin
        wr_io   = 1'b0;
        out_hit = 1'b0;
        wr_chan = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.wr_addr == ADDR_W'(IN_BASE + k)) begin
                wr_io = 1'b1;
            end
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (bus.wr_addr == ADDR_W'(OUT_BASE + k)) begin
                wr_io   = 1'b1;
                out_hit = bus.wr_en;
                wr_chan = 2'(k);
            end
        end
    end

    // Byte lanes let a single-byte write land without touching its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra_q <= '0;
            rb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                for (int w = 0; w < WORDS; w++) begin
                    lane_mem[i][w] <= 8'h00;
                end
            end
        end else begin
            ra_q <= bus.ra_addr;
            rb_q <= bus.rb_addr;
            if (bus.wr_en && !wr_io) begin
                lane_mem[bus.wr_addr[1:0]][bus.wr_addr[ADDR_W-1:2]] <= bus.wr_byte;
            end
        end
    end

    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int i = 0; i < 4; i++) begin
            word_a[8*i +: 8] = map_byte({ra_q, 2'(i)}, lane_mem[i][ra_q], bus.in_data, bus.in_valid);
            word_b[8*i +: 8] = map_byte({rb_q, 2'(i)}, lane_mem[i][rb_q], bus.in_data, bus.in_valid);
        end
        span = {word_b, word_a} >> {bus.pc_low, 3'b000};
    end

    assign bus.out_a   = span[7:0];
    assign bus.out_b   = span[15:8];
    assign bus.out_c   = span[23:16];
    assign bus.rb_byte = word_b[{bus.rb_byte_idx, 3'b000} +: 8];

    always_comb begin
        bus.in_ack = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (rst_n && bus.rd_consume && bus.in_valid[k] &&
                ({rb_q, bus.rb_byte_idx} == ADDR_W'(IN_BASE + k))) begin
                bus.in_ack[k] = 1'b1;
            end
        end
    end

    // A full FIFO refuses the write outright; the core holds it until stall drops.
    assign push       = out_hit & ~full;
    assign pop        = ~empty & bus.out_ready;
    assign bus.stall  = rst_n & out_hit & full;
    assign push_entry = '{chan: wr_chan, data: bus.wr_byte};

    sic1_out_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .full      (full),
        .pop       (pop),
        .pop_data  (head),
        .empty     (empty),
        .level     (bus.fifo_level)
    );

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? 8'h00 : head.data;
    assign bus.out_chan  = empty ? 2'b00 : head.chan;

endmodule

// File: tb/tb_sic1_io_memory.sv
// Self-checking bench for sic1_io_memory: directed scenarios with literal
// expectations, then randomized traffic checked against a byte-array/queue model.
module tb_sic1_io_memory;
    localparam int ADDR_W    = 8;
    localparam int NUM_IN    = 1;
    localparam int NUM_OUT   = 1;
    localparam int IN_BASE   = 253;
    localparam int OUT_BASE  = 254;
    localparam int OUT_DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    sic1_io_memory_if #(.ADDR_W(ADDR_W), .NUM_IN(NUM_IN), .OUT_DEPTH(OUT_DEPTH)) bus ();

    sic1_io_memory #(
        .ADDR_W    (ADDR_W),
        .NUM_IN    (NUM_IN),
        .NUM_OUT   (NUM_OUT),
        .IN_BASE   (IN_BASE),
        .OUT_BASE  (OUT_BASE),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]        mem_m [256];
    logic [9:0]        q_m [$];
    int                ra_m = 0;
    int                rb_m = 0;
    bit                live = 1'b0;
    bit                stall_last = 1'b0;
    logic [NUM_IN-1:0] ack_last = '0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_in(int a);
        return (a >= IN_BASE) && (a < IN_BASE + NUM_IN);
    endfunction

    function automatic bit is_out(int a);
        return (a >= OUT_BASE) && (a < OUT_BASE + NUM_OUT);
    endfunction

    function automatic logic [7:0] model_read(int a);
        if (is_in(a)) begin
            return bus.in_valid[a - IN_BASE] ? bus.in_data[8*(a - IN_BASE) +: 8] : 8'h00;
        end
        if (is_out(a)) begin
            return 8'h00;
        end
        return mem_m[a];
    endfunction

    function automatic int instr_addr(int j);
        int off;
        off = int'(bus.pc_low) + j;
        return (off < 4) ? ra_m * 4 + off : rb_m * 4 + off - 4;
    endfunction

    function automatic bit exp_ack(int k);
        return bus.rd_consume && bus.in_valid[k] &&
               (rb_m * 4 + int'(bus.rb_byte_idx) == IN_BASE + k);
    endfunction

    // Compare against the model, then advance it to what the coming rising edge does.
    always @(negedge clk) begin
        int         lvl;
        bit         hit;
        logic [9:0] head;
        if (!rst_n) begin
            checkOutput("stall_in_reset", 32'(bus.stall), 32'd0);
            checkOutput("in_ack_in_reset", 32'(bus.in_ack), 32'd0);
            foreach (mem_m[i]) mem_m[i] = 8'h00;
            q_m.delete();
            ra_m       = 0;
            rb_m       = 0;
            stall_last = 1'b0;
            ack_last   = '0;
            live       = 1'b1;
        end else if (live) begin
            lvl  = q_m.size();
            hit  = bus.wr_en && is_out(int'(bus.wr_addr));
            head = (lvl > 0) ? q_m[0] : 10'h000;
            checkOutput("out_a", 32'(bus.out_a), 32'(model_read(instr_addr(0))));
            checkOutput("out_b", 32'(bus.out_b), 32'(model_read(instr_addr(1))));
            checkOutput("out_c", 32'(bus.out_c), 32'(model_read(instr_addr(2))));
            checkOutput("rb_byte", 32'(bus.rb_byte), 32'(model_read(rb_m * 4 + int'(bus.rb_byte_idx))));
            for (int k = 0; k < NUM_IN; k++) begin
                checkOutput("in_ack", 32'(bus.in_ack[k]), 32'(exp_ack(k)));
            end
            checkOutput("out_valid", 32'(bus.out_valid), 32'(lvl > 0));
            checkOutput("out_data", 32'(bus.out_data), 32'(head[7:0]));
            checkOutput("out_chan", 32'(bus.out_chan), 32'(head[9:8]));
            checkOutput("stall", 32'(bus.stall), 32'(hit && lvl == OUT_DEPTH));
            checkOutput("fifo_level", 32'(bus.fifo_level), 32'(lvl));

            stall_last = hit && (lvl == OUT_DEPTH);
            for (int k = 0; k < NUM_IN; k++) ack_last[k] = exp_ack(k);
            if (lvl > 0 && bus.out_ready) void'(q_m.pop_front());
            if (hit && lvl < OUT_DEPTH) q_m.push_back({2'(int'(bus.wr_addr) - OUT_BASE), bus.wr_byte});
            if (bus.wr_en && !is_in(int'(bus.wr_addr)) && !is_out(int'(bus.wr_addr)))
                mem_m[bus.wr_addr] = bus.wr_byte;
            ra_m = int'(bus.ra_addr);
            rb_m = int'(bus.rb_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'(a);
        bus.wr_byte = 8'(d);
    endtask

    task automatic applyStimulus(input int n);
        step();
        rst_n = ($urandom_range(0, 149) != 0);
        if (!stall_last) begin
            bus.wr_en   = ($urandom_range(0, 1) == 0);
            bus.wr_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
            bus.wr_byte = 8'($urandom);
        end
        bus.ra_addr     = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom);
        bus.rb_addr     = ($urandom_range(0, 2) == 0) ? 6'd63 : 6'($urandom);
        bus.pc_low      = 2'($urandom);
        bus.rb_byte_idx = 2'($urandom);
        bus.rd_consume  = 1'($urandom);
        for (int k = 0; k < NUM_IN; k++) begin
            if (!(bus.in_valid[k] && !ack_last[k])) begin
                bus.in_valid[k]       = 1'($urandom);
                bus.in_data[8*k +: 8] = 8'($urandom);
            end
        end
        bus.out_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_byte = 0;
        bus.ra_addr = 0; bus.rb_addr = 0; bus.pc_low = 0; bus.rb_byte_idx = 0;
        bus.rd_consume = 0; bus.in_data = 0; bus.in_valid = 0; bus.out_ready = 0;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_chan", 32'(bus.out_chan), 32'd0);
        checkOutput("rst_stall", 32'(bus.stall), 32'd0);
        checkOutput("rst_in_ack", 32'(bus.in_ack), 32'd0);

        for (int i = 0; i < 4; i++) begin step(); wr(i, 17 * (i + 1)); end
        step(); bus.wr_en = 0; bus.ra_addr = 0; bus.pc_low = 1;
        step();
        @(negedge clk);
        checkOutput("byte_wr_a", 32'(bus.out_a), 32'h22);
        checkOutput("byte_wr_b", 32'(bus.out_b), 32'h33);
        checkOutput("byte_wr_c", 32'(bus.out_c), 32'h44);

        for (int i = 0; i < 4; i++) begin step(); wr(4 + i, 8'h55 + 8'h11 * i); end
        step(); bus.wr_en = 0; bus.rb_addr = 1; bus.pc_low = 3; bus.rb_byte_idx = 2;
        step();
        @(negedge clk);
        checkOutput("span_a", 32'(bus.out_a), 32'h44);
        checkOutput("span_b", 32'(bus.out_b), 32'h55);
        checkOutput("span_c", 32'(bus.out_c), 32'h66);
        checkOutput("span_rb", 32'(bus.rb_byte), 32'h77);

        step(); bus.in_data = 8'h5A; bus.in_valid = 1; bus.rb_addr = 63; bus.rb_byte_idx = 1; bus.rd_consume = 1;
        step();
        @(negedge clk);
        checkOutput("in_rb_byte", 32'(bus.rb_byte), 32'h5A);
        checkOutput("in_ack_hit", 32'(bus.in_ack), 32'd1);
        step(); bus.in_valid = 0;
        @(negedge clk);
        checkOutput("in_rb_novalid", 32'(bus.rb_byte), 32'h00);
        checkOutput("in_ack_novalid", 32'(bus.in_ack), 32'd0);

        step(); bus.rd_consume = 0; bus.out_ready = 0;
        for (int i = 1; i <= 4; i++) begin wr(OUT_BASE, i); step(); end
        wr(OUT_BASE, 5);
        @(negedge clk);
        checkOutput("fill_stall", 32'(bus.stall), 32'd1);
        checkOutput("fill_level", 32'(bus.fifo_level), 32'd4);
        checkOutput("fill_head", 32'(bus.out_data), 32'h01);
        step(); bus.out_ready = 1;
        @(negedge clk);
        checkOutput("fill_stall_ready", 32'(bus.stall), 32'd1);
        step();
        @(negedge clk);
        checkOutput("drain_level", 32'(bus.fifo_level), 32'd3);
        checkOutput("drain_stall", 32'(bus.stall), 32'd0);
        checkOutput("drain_head", 32'(bus.out_data), 32'h02);
        step(); bus.wr_en = 0; bus.out_ready = 0;
        @(negedge clk);
        checkOutput("accept5_level", 32'(bus.fifo_level), 32'd3);
        checkOutput("accept5_head", 32'(bus.out_data), 32'h03);

        step(); bus.out_ready = 1;
        step(); bus.out_ready = 0;
        @(negedge clk);
        checkOutput("lvl2_level", 32'(bus.fifo_level), 32'd2);
        step(); wr(OUT_BASE, 8'h66); bus.out_ready = 1;
        step(); bus.wr_en = 0; bus.out_ready = 0;
        @(negedge clk);
        checkOutput("pushpop_level", 32'(bus.fifo_level), 32'd2);
        checkOutput("pushpop_head", 32'(bus.out_data), 32'h05);
        step(); bus.out_ready = 1;
        step();
        @(negedge clk);
        checkOutput("order_head", 32'(bus.out_data), 32'h66);
        step(); bus.out_ready = 0;
        @(negedge clk);
        checkOutput("empty_valid", 32'(bus.out_valid), 32'd0);

        step(); wr(255, 8'hAB);
        step(); bus.wr_en = 0; bus.ra_addr = 63; bus.pc_low = 2;
        step();
        @(negedge clk);
        checkOutput("read_out_addr", 32'(bus.out_a), 32'h00);
        checkOutput("read_halt_addr", 32'(bus.out_b), 32'hAB);

        for (int i = 0; i < 4; i++) begin step(); wr(OUT_BASE, 8'hA0 + i); end
        step(); wr(OUT_BASE, 8'hA4);
        @(negedge clk);
        checkOutput("pre_rst_stall", 32'(bus.stall), 32'd1);
        step(); bus.in_valid = 1; bus.in_data = 8'h77; bus.rb_byte_idx = 1; bus.rd_consume = 1;
        @(negedge clk);
        checkOutput("pre_rst_ack", 32'(bus.in_ack), 32'd1);
        step(); rst_n = 0;
        @(negedge clk);
        checkOutput("mid_rst_stall", 32'(bus.stall), 32'd0);
        checkOutput("mid_rst_ack", 32'(bus.in_ack), 32'd0);
        step(); rst_n = 1; bus.wr_en = 0; bus.rd_consume = 0; bus.in_valid = 0;
        @(negedge clk);
        checkOutput("post_rst_level", 32'(bus.fifo_level), 32'd0);
        checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("post_rst_stall", 32'(bus.stall), 32'd0);
        for (int w = 0; w < 64; w++) begin
            step(); bus.ra_addr = 6'(w); bus.rb_addr = 6'(w); bus.pc_low = 0; bus.rb_byte_idx = 3;
            step();
            @(negedge clk);
            checkOutput("post_rst_word", {bus.out_a, bus.out_b, bus.out_c, bus.rb_byte}, 32'd0);
        end

        for (int n = 0; n < 3000; n++) applyStimulus(n);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
